// File: rtl/input_io_ctrl.sv
// Purpose : memory-mapped switch/button input block with debounce, edge capture and level IRQ.
// Latency : 2-cycle input synchronizer, DB_CYCLES debounce window, 1-cycle registered read.
// Backpress: none; register slave accepts a write every cycle and returns read data every cycle.
module input_io_ctrl #(
    parameter int          SW_W      = 32,
    parameter int          BTN_W     = 4,
    parameter int          DB_CYCLES = 16,
    parameter logic [15:0] BASE_ADDR = 16'h7800
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [SW_W-1:0]  i_io_sw,
    input  logic [BTN_W-1:0] i_io_btn,
    input  logic [15:0]      i_ip_addr,
    input  logic             i_wren,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_ip_data,
    output logic             o_irq
);

    // Counter only has to reach DB_CYCLES-1, so clog2 bits suffice (DB_CYCLES >= 2).
    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // Register byte addresses; decode compares word addresses only.
    localparam logic [15:0] SW_ADDR   = BASE_ADDR + 16'h0000;
    localparam logic [15:0] BTN_ADDR  = BASE_ADDR + 16'h0010;
    localparam logic [15:0] EDGE_ADDR = BASE_ADDR + 16'h0014;
    localparam logic [15:0] MASK_ADDR = BASE_ADDR + 16'h0018;

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    logic [SW_W-1:0]  sw_meta;
    logic [SW_W-1:0]  sw_sync;
    logic [BTN_W-1:0] btn_meta;
    logic [BTN_W-1:0] btn_sync;

    // Two-flop synchronizers bring the raw levels into the i_clk domain.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= i_io_sw;
            sw_sync  <= sw_meta;
            btn_meta <= i_io_btn;
            btn_sync <= btn_meta;
        end
    end

    // ------------------------------------------------------------------
    // Per-button debounce
    // ------------------------------------------------------------------
    logic [BTN_W-1:0] stable;
    logic [BTN_W-1:0] stable_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < BTN_W; gi++) begin : g_db
            logic [CNT_W-1:0] cnt;
            logic [CNT_W-1:0] cnt_nxt;
            logic             stb_nxt;

            // Count consecutive mismatch cycles; any agreement restarts the window.
            always_comb begin
                cnt_nxt = '0;
                stb_nxt = stable[gi];
                if (btn_sync[gi] != stable[gi]) begin
                    if (cnt == CNT_LAST) begin
                        stb_nxt = btn_sync[gi];
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end

            // Debounce counter state; reset abandons any window in progress.
            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt_nxt;
                end
            end

            assign stable_nxt[gi] = stb_nxt;
        end
    endgenerate

    // Stable (debounced) button levels.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            stable <= '0;
        end else begin
            stable <= stable_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic hit_sw;
    logic hit_btn;
    logic hit_edge;
    logic hit_mask;

    assign hit_sw   = (i_ip_addr[15:2] == SW_ADDR[15:2]);
    assign hit_btn  = (i_ip_addr[15:2] == BTN_ADDR[15:2]);
    assign hit_edge = (i_ip_addr[15:2] == EDGE_ADDR[15:2]);
    assign hit_mask = (i_ip_addr[15:2] == MASK_ADDR[15:2]);

    // ------------------------------------------------------------------
    // EDGE and MASK registers
    // ------------------------------------------------------------------
    logic [BTN_W-1:0] edge_flags;
    logic [BTN_W-1:0] edge_nxt;
    logic [BTN_W-1:0] edge_clr;
    logic [BTN_W-1:0] rise;
    logic [BTN_W-1:0] mask_reg;

    // Rising edge is taken from the stable bit as it is updated, so EDGE sets on the same edge.
    // Clear is applied before set so a coincident rise survives a write-1-to-clear.
    always_comb begin
        rise     = stable_nxt & ~stable;
        edge_clr = '0;
        if (i_wren && hit_edge) begin
            edge_clr = i_wdata[BTN_W-1:0];
        end
        edge_nxt = (edge_flags & ~edge_clr) | rise;
    end

    // EDGE flags update every cycle from captured rises and software clears.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            edge_flags <= '0;
        end else begin
            edge_flags <= edge_nxt;
        end
    end

    // MASK is a plain software register; bits above BTN_W do not exist.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            mask_reg <= '0;
        end else if (i_wren && hit_mask) begin
            mask_reg <= i_wdata[BTN_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [31:0] rd_data;

    // Read mux uses pre-write register values; unmapped words return zero.
    always_comb begin
        rd_data = '0;
        if (hit_sw) begin
            rd_data[SW_W-1:0] = sw_sync;
        end else if (hit_btn) begin
            rd_data[BTN_W-1:0] = stable;
        end else if (hit_edge) begin
            rd_data[BTN_W-1:0] = edge_flags;
        end else if (hit_mask) begin
            rd_data[BTN_W-1:0] = mask_reg;
        end
    end

    // Read data is registered every cycle, independent of the write strobe.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_ip_data <= '0;
        end else begin
            o_ip_data <= rd_data;
        end
    end

    // Interrupt is a pure function of registered state, so it is zero in reset.
    assign o_irq = |(edge_flags & mask_reg);

    // Byte-lane address bits and unused write-data bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{i_ip_addr[1:0], i_wdata};

endmodule

// File: tb/tb_input_io_ctrl.sv
// Purpose : directed self-checking bench for input_io_ctrl with default parameters.
// Latency : expectations hand-derived from 2-flop sync, 16-cycle debounce, 1-cycle read.
// Backpress: not applicable; stimulus is applied one cycle at a time.
module tb_input_io_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] sw;
    logic [3:0]  btn;
    logic [15:0] addr;
    logic        wren;
    logic [31:0] wdata;
    logic [31:0] rd_dat;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    input_io_ctrl #(
        .SW_W      (32),
        .BTN_W     (4),
        .DB_CYCLES (16),
        .BASE_ADDR (16'h7800)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .i_io_sw   (sw),
        .i_io_btn  (btn),
        .i_ip_addr (addr),
        .i_wren    (wren),
        .i_wdata   (wdata),
        .o_ip_data (rd_dat),
        .o_irq     (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sw    = 32'hDEADBEEF;
        btn   = 4'h0;
        addr  = 16'h7800;
        wren  = 1'b0;
        wdata = 32'h0;

        // Reset state
        #3;
        check_eq("reset_rdata", rd_dat, 32'h0);
        check_eq("reset_irq", {31'b0, irq}, 32'h0);

        // Switch read: 2 sync edges + 1 read edge
        tick();
        rst_n = 1'b1;
        tick(2);
        check_eq("sw_before_latency", rd_dat, 32'h0);
        tick();
        check_eq("sw_read", rd_dat, 32'hDEADBEEF);

        // btn[0] clean step: stable on 18th edge, visible on read after 19th
        addr = 16'h7810;
        btn  = 4'h1;
        tick(18);
        check_eq("btn0_edge18", rd_dat, 32'h0);
        tick();
        check_eq("btn0_edge19", rd_dat, 32'h1);
        addr = 16'h7814;
        tick();
        check_eq("edge0_set", rd_dat, 32'h1);
        check_eq("irq_unmasked", {31'b0, irq}, 32'h0);

        // btn[1] 10-cycle glitch is rejected
        btn = 4'h3;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq("glitch_irq", {31'b0, irq}, 32'h0);
        end
        btn = 4'h1;
        tick(25);
        addr = 16'h7810;
        tick();
        check_eq("glitch_btn", rd_dat, 32'h1);
        addr = 16'h7814;
        tick();
        check_eq("glitch_edge", rd_dat, 32'h1);

        // MASK write with upper bits set; irq follows immediately
        addr  = 16'h7818;
        wren  = 1'b1;
        wdata = 32'hFFFF_FFF1;
        tick();
        wren = 1'b0;
        check_eq("irq_after_mask", {31'b0, irq}, 32'h1);
        tick();
        check_eq("mask_read", rd_dat, 32'h1);

        // EDGE clear: same-cycle read returns pre-write value
        addr  = 16'h7814;
        wren  = 1'b1;
        wdata = 32'h1;
        tick();
        wren = 1'b0;
        check_eq("edge_prewrite_read", rd_dat, 32'h1);
        check_eq("irq_after_clear", {31'b0, irq}, 32'h0);
        tick();
        check_eq("edge_cleared", rd_dat, 32'h0);

        // Writes to RO and unmapped addresses leave MASK alone
        wren  = 1'b1;
        wdata = 32'h0;
        addr  = 16'h7800;
        tick();
        addr  = 16'h7FFF;
        tick();
        addr  = 16'h7810;
        tick();
        wren = 1'b0;
        addr = 16'h781B;
        tick();
        check_eq("mask_after_ro_writes", rd_dat, 32'h1);
        addr = 16'h7FFF;
        tick();
        check_eq("unmapped_7fff", rd_dat, 32'h0);
        addr = 16'h7804;
        tick();
        check_eq("unmapped_7804", rd_dat, 32'h0);

        // Falling edge of btn[0] sets nothing
        btn = 4'h0;
        tick(25);
        addr = 16'h7814;
        tick();
        check_eq("no_edge_on_fall", rd_dat, 32'h0);

        // Clear coincident with a new rise on bit 0: set wins
        btn = 4'h1;
        tick(17);
        check_eq("irq_before_rise", {31'b0, irq}, 32'h0);
        wren  = 1'b1;
        wdata = 32'h1;
        tick();
        wren = 1'b0;
        check_eq("irq_set_wins", {31'b0, irq}, 32'h1);
        tick();
        check_eq("edge_set_wins", rd_dat, 32'h1);

        // Reset mid-debounce of btn[2]
        btn  = 4'h5;
        addr = 16'h7810;
        tick(8);
        rst_n = 1'b0;
        #2;
        check_eq("async_rst_rdata", rd_dat, 32'h0);
        check_eq("async_rst_irq", {31'b0, irq}, 32'h0);
        tick();
        check_eq("held_rst_rdata", rd_dat, 32'h0);
        rst_n = 1'b1;
        tick(18);
        check_eq("post_rst_btn_edge18", rd_dat, 32'h0);
        tick();
        check_eq("post_rst_btn_edge19", rd_dat, 32'h5);
        addr = 16'h7814;
        tick();
        check_eq("post_rst_edge", rd_dat, 32'h5);
        addr = 16'h7818;
        tick();
        check_eq("post_rst_mask", rd_dat, 32'h0);
        check_eq("post_rst_irq", {31'b0, irq}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/input_io_ctrl.md
INPUT_IO_CTRL -- requirements
Module: input_io_ctrl

Interface
REQ-001 Parameter SW_W, default 32, number of switch input bits (1..32).
REQ-002 Parameter BTN_W, default 4, number of button input bits (1..32).
REQ-003 Parameter DB_CYCLES, default 16, debounce stability window in clock cycles (>=2).
REQ-004 Parameter BASE_ADDR, default 16'h7800, base of the register window.
REQ-005 i_clk  in  1  single clock; all state on rising edge.
REQ-006 i_rst  in  1  reset, asynchronous, active-low.
REQ-007 i_io_sw  in  SW_W  raw switch levels, asynchronous to i_clk.
REQ-008 i_io_btn  in  BTN_W  raw button levels, asynchronous, bouncy.
REQ-009 i_ip_addr  in  16  byte address; bits [1:0] ignored in decode.
REQ-010 i_wren  in  1  write strobe, one cycle per write.
REQ-011 i_wdata  in  32  write data.
REQ-012 o_ip_data  out  32  registered read data.
REQ-013 o_irq  out  1  level interrupt, active-high.

Function
REQ-014 Register map (offset from BASE_ADDR): 0x00 SW (RO), 0x10 BTN level (RO), 0x14 EDGE (RW, write-1-to-clear), 0x18 MASK (RW); all other addresses unmapped.
REQ-015 Each switch and button bit shall pass a two-flop synchronizer before any other use.
REQ-016 SW register shall read the synchronized switch value zero-extended to 32 bits.
REQ-017 Each button bit shall own a debounce counter and a stable bit; counter clears whenever synced value equals stable.
REQ-018 While synced differs from stable, counter increments each cycle; on the cycle it equals DB_CYCLES-1 with mismatch still present, stable takes synced value and counter clears.
REQ-019 Any return of synced to stable before that cycle clears the counter (glitch rejected, no stable change).
REQ-020 Latency raw input change to stable change: exactly 2 + DB_CYCLES cycles for a clean step.
REQ-021 BTN register reads stable bits zero-extended; EDGE bit n sets on the cycle stable[n] goes 0->1.
REQ-022 EDGE write: bits with i_wdata=1 clear, others unchanged; simultaneous set and clear on the same bit, set wins.
REQ-023 MASK write loads i_wdata[BTN_W-1:0]; upper bits ignored on write, read as zero.
REQ-024 Writes to RO or unmapped addresses have no effect.
REQ-025 Read: o_ip_data updates on the rising edge after i_ip_addr is presented (one-cycle latency), every cycle regardless of i_wren.
REQ-026 Unmapped address reads return 32'h0.
REQ-027 Read of EDGE in the same cycle as an EDGE write returns the pre-write value.
REQ-028 o_irq = OR of (EDGE & MASK), derived from registered state only, no extra latency.

Reset
REQ-029 While i_rst=0: synchronizers, stable bits, counters, EDGE, MASK and o_ip_data shall be 0 immediately, independent of i_clk.
REQ-030 o_irq shall be 0 during reset; reset asserted mid-debounce abandons the count; no edge reported on release unless input is high and a full debounce completes afterwards.

Verification
REQ-031 Reset release, i_io_sw=32'hDEADBEEF, addr 0x7800 -> o_ip_data=32'hDEADBEEF within 3 cycles (2 sync + 1 read).
REQ-032 btn[0] clean step 0->1, DB_CYCLES=16, addr 0x7810 -> BTN reads 0x1 exactly 18 cycles after step (+1 read), EDGE 0x7814 reads 0x1.
REQ-033 btn[1] pulse high for 10 cycles (< DB_CYCLES) -> BTN and EDGE stay 0x0, o_irq stays 0.
REQ-034 MASK=0x1 written at 0x7818, EDGE[0] set -> o_irq=1; write 0x1 to 0x7814 -> EDGE=0x0, o_irq=0 next cycle.
REQ-035 EDGE clear write coincident with new rising edge on the same bit -> EDGE bit remains 1.
REQ-036 addr 0x7FFF read -> 32'h0; i_rst pulsed low mid-debounce -> all reads 0x0, o_irq=0 asynchronously.
